// File: rtl/serial_fifo_transceiver.sv
// rtl/serial_fifo_transceiver.sv - UART-style transceiver with RX/TX FIFOs and echo path
// Oversampled majority-vote receiver, registered-line transmitter, FWFT RX FIFO.

module serial_fifo_transceiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // Callers gate wr/rd against full/empty; this block only moves pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module serial_fifo_transceiver #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int SAMPLE_RATIO = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  output logic                 dout,
  input  logic                 echo_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int TICK_RAW = CLK_FREQ / BAUD_RATE / SAMPLE_RATIO;
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(SAMPLE_RATIO);

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(SAMPLE_RATIO - 1);
  localparam logic [SW-1:0] MID_LO    = SW'(SAMPLE_RATIO / 2 - 1);
  localparam logic [SW-1:0] MID       = SW'(SAMPLE_RATIO / 2);
  localparam logic [SW-1:0] MID_HI    = SW'(SAMPLE_RATIO / 2 + 1);
  localparam logic [3:0]    DB_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          run;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      run      <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      run      <= 1'b1;
    end
  end

  // Receiver
  logic                 s1, s2, s3;
  rx_state_t            rx_state, rx_next;
  logic [SW-1:0]        scnt;
  logic [3:0]           rbit;
  logic [2:0]           votes;
  logic [DATA_BITS-1:0] rsh;
  logic                 rpar;
  logic                 rx_bit_end, rx_done, maj_reg, stop_ok, par_bad, good;

  assign rx_bit_end = tick && (scnt == S_LAST);
  assign maj_reg    = maj3(votes);
  // The stop decision uses the third sample as it arrives so RX is idle by mid-stop.
  assign stop_ok    = maj3({votes[1:0], s2});
  assign par_bad    = (PARITY != 0) && (rpar != par_of(rsh));
  assign good       = rx_done && stop_ok && !par_bad;

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      R_IDLE:   if (s3 && !s2) rx_next = R_START;
      R_START:  if (rx_bit_end) rx_next = maj_reg ? R_IDLE : R_DATA;
      R_DATA:   if (rx_bit_end && rbit == DB_LAST) rx_next = (PARITY != 0) ? R_PARITY : R_STOP;
      R_PARITY: if (rx_bit_end) rx_next = R_STOP;
      R_STOP: begin
        if (tick && scnt == MID_HI) begin
          rx_next = R_IDLE;
          rx_done = 1'b1;
        end
      end
      default:  rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      rx_state <= R_IDLE;
      scnt     <= '0;
      rbit     <= '0;
      votes    <= '0;
      rsh      <= '0;
      rpar     <= 1'b0;
    end else begin
      s1       <= din;
      s2       <= s1;
      s3       <= s2;
      rx_state <= rx_next;
      if (rx_state == R_IDLE) scnt <= '0;
      else if (tick)          scnt <= rx_bit_end ? '0 : scnt + 1'b1;
      if (rx_state != R_IDLE && tick && (scnt == MID_LO || scnt == MID || scnt == MID_HI))
        votes <= {votes[1:0], s2};
      if (rx_bit_end) rbit <= (rx_next != rx_state) ? '0 : rbit + 1'b1;
      if (rx_state == R_DATA && rx_bit_end)   rsh  <= {maj_reg, rsh[DATA_BITS-1:1]};
      if (rx_state == R_PARITY && rx_bit_end) rpar <= maj_reg;
    end
  end

  // FIFO routing
  logic [DATA_BITS-1:0] echo_word, tx_wdata, tx_head;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic                 echo_push, user_push, tx_wr, tx_pop, rx_push, rx_pop;

  assign echo_word = rsh[DATA_BITS-1] ? ~rsh : rsh;
  assign tx_ready  = run && !echo_en && !tx_full;
  assign user_push = tx_valid && tx_ready;
  assign echo_push = good && echo_en && !tx_full;
  assign tx_wr     = echo_push || user_push;
  assign tx_wdata  = echo_push ? echo_word : tx_data;
  assign rx_valid  = !rx_empty;
  assign rx_pop    = rx_ready && rx_valid;
  assign rx_push   = good && !echo_en && (!rx_full || rx_pop);

  serial_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(rx_push), .wdata(rsh), .rd(rx_pop),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  serial_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= rx_done && par_bad;
      frame_err  <= rx_done && !stop_ok;
      overrun    <= good && (echo_en ? tx_full : (rx_full && !rx_pop));
    end
  end

  // Transmitter
  tx_state_t            tx_state, tx_next;
  logic [SW-1:0]        tcnt;
  logic [3:0]           tbit;
  logic [DATA_BITS-1:0] tsh;
  logic                 tpar;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tcnt == S_LAST);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_next = T_START;
        end
      end
      T_START:  if (tx_bit_end) tx_next = T_DATA;
      T_DATA:   if (tx_bit_end && tbit == DB_LAST) tx_next = (PARITY != 0) ? T_PARITY : T_STOP;
      T_PARITY: if (tx_bit_end) tx_next = T_STOP;
      T_STOP: begin
        if (tx_bit_end && tbit == SB_LAST) begin
          tx_pop  = !tx_empty;
          tx_next = tx_empty ? T_IDLE : T_START;
        end
      end
      default:  tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tcnt     <= '0;
      tbit     <= '0;
      tsh      <= '0;
      tpar     <= 1'b0;
      dout     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_state == T_IDLE) tcnt <= '0;
      else if (tick)          tcnt <= tx_bit_end ? '0 : tcnt + 1'b1;
      if (tx_bit_end) tbit <= (tx_next != tx_state) ? '0 : tbit + 1'b1;
      if (tx_pop) begin
        tsh  <= tx_head;
        tpar <= par_of(tx_head);
      end else if (tx_state == T_DATA && tx_bit_end) begin
        tsh <= tsh >> 1;
      end
      case (tx_state)
        T_START:  dout <= 1'b0;
        T_DATA:   dout <= tsh[0];
        T_PARITY: dout <= tpar;
        default:  dout <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fifo_transceiver.sv
// tb/tb_serial_fifo_transceiver.sv - directed bench for serial_fifo_transceiver
// dut_np: no parity, 16-deep; dut: even parity, 4-deep. One bit = 16 clocks.

module tb_serial_fifo_transceiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       din_np, echo_en_np, tx_valid_np, rx_ready_np;
  logic [7:0] tx_data_np, rx_data_np;
  logic       dout_np, tx_ready_np, rx_valid_np, perr_np, ferr_np, ovr_np;
  logic       din, echo_en, tx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;
  logic       dout, tx_ready, rx_valid, perr, ferr, ovr;

  serial_fifo_transceiver #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .SAMPLE_RATIO(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_np (
    .clk(clk), .rst_n(rst_n), .din(din_np), .dout(dout_np), .echo_en(echo_en_np),
    .tx_data(tx_data_np), .tx_valid(tx_valid_np), .tx_ready(tx_ready_np),
    .rx_data(rx_data_np), .rx_valid(rx_valid_np), .rx_ready(rx_ready_np),
    .parity_err(perr_np), .frame_err(ferr_np), .overrun(ovr_np)
  );

  serial_fifo_transceiver #(
    .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .SAMPLE_RATIO(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .echo_en(echo_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(perr), .frame_err(ferr), .overrun(ovr)
  );

  int checks = 0;
  int errors = 0;
  int perr_n = 0;
  int ferr_n = 0;
  int ovr_n  = 0;
  logic [9:0] dec_q[$];

  always @(negedge clk) begin
    if (perr === 1'b1) perr_n++;
    if (ferr === 1'b1) ferr_n++;
    if (ovr === 1'b1)  ovr_n++;
  end

  // Line decoder for dut.dout: stores {stop, parity, data} per frame.
  always begin : decode
    logic [9:0] w;
    @(negedge clk);
    if (rst_n === 1'b1 && dout === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        repeat (16) @(negedge clk);
        w[i] = dout;
      end
      dec_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic b);
    din = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(p);
    bit_time(s);
    din = 1'b1;
  endtask

  task automatic pop;
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic wait_np_low;
    int n;
    n = 0;
    while (dout_np !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("np_start_seen", dout_np, 1'b0);
  endtask

  initial begin
    int n, p0, f0, o0, q0;
    logic [7:0] v;
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst_n = 1'b0;
    din = 1'b1; echo_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    din_np = 1'b1; echo_en_np = 1'b0; tx_valid_np = 1'b0; tx_data_np = 8'h00; rx_ready_np = 1'b0;
    cycles(3);
    chk("rst_dout", dout, 1'b1);
    chk("rst_dout_np", dout_np, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_flags", {perr, ferr, ovr}, 3'b000);

    rst_n = 1'b1;
    chk("tx_ready_held", tx_ready_np, 1'b0);
    cycles(1);
    chk("tx_ready_rise_np", tx_ready_np, 1'b1);
    chk("tx_ready_rise", tx_ready, 1'b1);

    // 0x55 without parity: 0,1,0,1,0,1,0,1,0,1 then idle
    v = 8'h55;
    tx_data_np = v; tx_valid_np = 1'b1;
    cycles(1);
    tx_valid_np = 1'b0;
    wait_np_low();
    n = 0;
    while (dout_np === 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tx55_start_len", n, 16);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tx55_bit%0d", i), dout_np, (i < 8) ? v[i] : 1'b1);
      repeat (16) @(negedge clk);
    end
    chk("tx55_idle", dout_np, 1'b1);
    cycles(1);

    // good frame 0xA3, even parity 0
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'hA3, 1'b0, 1'b1);
    cycles(4);
    chk("rxA3_valid", rx_valid, 1'b1);
    chk("rxA3_data", rx_data, 8'hA3);
    chk("rxA3_perr", perr_n - p0, 0);
    chk("rxA3_ferr", ferr_n - f0, 0);
    pop();
    chk("rxA3_popped", rx_valid, 1'b0);

    // bad parity, then bad stop
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'hA3, 1'b1, 1'b1);
    cycles(4);
    chk("par_perr", perr_n - p0, 1);
    chk("par_ferr", ferr_n - f0, 0);
    chk("par_rx_valid", rx_valid, 1'b0);
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'hA3, 1'b0, 1'b0);
    cycles(20);
    chk("stop_ferr", ferr_n - f0, 1);
    chk("stop_perr", perr_n - p0, 0);
    chk("stop_rx_valid", rx_valid, 1'b0);

    // echo: 0x81 -> 0x7E, 0x12 -> 0x12, each with even parity 0
    echo_en = 1'b1;
    q0 = dec_q.size();
    send_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    chk("echo_tx_ready", tx_ready, 1'b0);
    n = 0;
    while (dec_q.size() < q0 + 2 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("echo_count", dec_q.size(), q0 + 2);
    chk("echo_word0", dec_q[q0], 10'h27E);
    chk("echo_word1", dec_q[q0 + 1], 10'h212);
    chk("echo_rx_valid", rx_valid, 1'b0);
    cycles(1);
    echo_en = 1'b0;

    // five words into a 4-deep RX FIFO
    p0 = perr_n; f0 = ferr_n; o0 = ovr_n;
    for (int i = 0; i < 5; i++) send_frame(words[i], ^words[i], 1'b1);
    cycles(4);
    chk("ovr_count", ovr_n - o0, 1);
    chk("ovr_perr", perr_n - p0, 0);
    chk("ovr_ferr", ferr_n - f0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fifo_valid%0d", i), rx_valid, 1'b1);
      chk($sformatf("fifo_data%0d", i), rx_data, words[i]);
      pop();
    end
    chk("fifo_drained", rx_valid, 1'b0);

    // 2-cycle glitch on din
    p0 = perr_n; f0 = ferr_n; o0 = ovr_n;
    din = 1'b0;
    cycles(2);
    din = 1'b1;
    cycles(40);
    chk("glitch_flags", (perr_n - p0) + (ferr_n - f0) + (ovr_n - o0), 0);
    chk("glitch_rx_valid", rx_valid, 1'b0);

    // reset mid-frame
    send_frame(8'h5A, 1'b0, 1'b1);
    cycles(4);
    chk("pre_rst_rx_valid", rx_valid, 1'b1);
    tx_valid_np = 1'b1; tx_data_np = 8'hA5;
    cycles(1);
    tx_data_np = 8'h3C;
    cycles(1);
    tx_valid_np = 1'b0;
    wait_np_low();
    repeat (40) @(negedge clk);
    chk("tx_mid_low", dout_np, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dout", dout_np, 1'b1);
    chk("rst_mid_rx_valid", rx_valid, 1'b0);
    chk("rst_mid_tx_ready", tx_ready_np, 1'b0);
    cycles(3);
    rst_n = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (dout_np !== 1'b1) n++;
    end
    chk("post_rst_line_idle", n, 0);
    chk("post_rst_rx_valid", rx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
